// File: rtl/axil_wr_arbiter_2x1.sv
// Two-master AXI-Lite write arbiter onto one shared slave write port.
// Round-robin on AW requests, a single transaction in flight at a time.
module axil_wr_arbiter_2x1 #(
    parameter int ADDR_WIDTH = 24,
    parameter int DATA_WIDTH = 32,
    parameter int STRB_WIDTH = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic [ADDR_WIDTH-1:0] s0_awaddr,
    input  logic [2:0]            s0_awprot,
    input  logic                  s0_awvalid,
    output logic                  s0_awready,
    input  logic [DATA_WIDTH-1:0] s0_wdata,
    input  logic [STRB_WIDTH-1:0] s0_wstrb,
    input  logic                  s0_wvalid,
    output logic                  s0_wready,
    output logic [1:0]            s0_bresp,
    output logic                  s0_bvalid,
    input  logic                  s0_bready,

    input  logic [ADDR_WIDTH-1:0] s1_awaddr,
    input  logic [2:0]            s1_awprot,
    input  logic                  s1_awvalid,
    output logic                  s1_awready,
    input  logic [DATA_WIDTH-1:0] s1_wdata,
    input  logic [STRB_WIDTH-1:0] s1_wstrb,
    input  logic                  s1_wvalid,
    output logic                  s1_wready,
    output logic [1:0]            s1_bresp,
    output logic                  s1_bvalid,
    input  logic                  s1_bready,

    output logic [ADDR_WIDTH-1:0] m_awaddr,
    output logic [2:0]            m_awprot,
    output logic                  m_awvalid,
    input  logic                  m_awready,
    output logic [DATA_WIDTH-1:0] m_wdata,
    output logic [STRB_WIDTH-1:0] m_wstrb,
    output logic                  m_wvalid,
    input  logic                  m_wready,
    input  logic [1:0]            m_bresp,
    input  logic                  m_bvalid,
    output logic                  m_bready
);

    typedef enum logic [1:0] {IDLE, XFER, RESP} state_t;

    state_t state, state_d;
    logic   grant, grant_d;
    logic   last, last_d;
    logic   aw_done, aw_done_d;
    logic   w_done, w_done_d;

    logic sel_awvalid, sel_wvalid, sel_bready;
    logic aw_hs, w_hs, b_hs;
    logic aw_rdy, w_rdy, b_vld;
    logic in_xfer, in_resp;

    // Payload always follows the grant register; valids gate its meaning.
    assign m_awaddr = grant ? s1_awaddr : s0_awaddr;
    assign m_awprot = grant ? s1_awprot : s0_awprot;
    assign m_wdata  = grant ? s1_wdata  : s0_wdata;
    assign m_wstrb  = grant ? s1_wstrb  : s0_wstrb;

    assign sel_awvalid = grant ? s1_awvalid : s0_awvalid;
    assign sel_wvalid  = grant ? s1_wvalid  : s0_wvalid;
    assign sel_bready  = grant ? s1_bready  : s0_bready;

    assign in_xfer = (state == XFER);
    assign in_resp = (state == RESP);

    assign m_awvalid = in_xfer && !aw_done && sel_awvalid;
    assign m_wvalid  = in_xfer && !w_done && sel_wvalid;
    assign m_bready  = in_resp && sel_bready;

    assign aw_hs = m_awvalid && m_awready;
    assign w_hs  = m_wvalid && m_wready;
    assign b_hs  = m_bvalid && m_bready;

    assign aw_rdy = in_xfer && !aw_done && m_awready;
    assign w_rdy  = in_xfer && !w_done && m_wready;
    assign b_vld  = in_resp && m_bvalid;

    assign s0_awready = aw_rdy && !grant;
    assign s1_awready = aw_rdy && grant;
    assign s0_wready  = w_rdy && !grant;
    assign s1_wready  = w_rdy && grant;
    assign s0_bvalid  = b_vld && !grant;
    assign s1_bvalid  = b_vld && grant;
    assign s0_bresp   = (in_resp && !grant) ? m_bresp : 2'b00;
    assign s1_bresp   = (in_resp && grant) ? m_bresp : 2'b00;

    // last starts at 1 so master 0 wins the first tie after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            grant   <= 1'b0;
            last    <= 1'b1;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
        end else begin
            state   <= state_d;
            grant   <= grant_d;
            last    <= last_d;
            aw_done <= aw_done_d;
            w_done  <= w_done_d;
        end
    end

    always_comb begin
        state_d   = state;
        grant_d   = grant;
        last_d    = last;
        aw_done_d = aw_done;
        w_done_d  = w_done;
        case (state)
            IDLE: begin
                // Only AW valid counts as a request; early W data waits.
                if (s0_awvalid || s1_awvalid) begin
                    grant_d = (s0_awvalid && s1_awvalid) ? ~last : s1_awvalid;
                    state_d = XFER;
                end
            end
            XFER: begin
                aw_done_d = aw_done || aw_hs;
                w_done_d  = w_done || w_hs;
                if (aw_done_d && w_done_d) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                if (b_hs) begin
                    last_d    = grant;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_axil_wr_arbiter_2x1.sv
// Bench for axil_wr_arbiter_2x1: two master drivers, a simple slave model,
// and a scoreboard matching slave-side captures against expected writes.
module tb_axil_wr_arbiter_2x1;

    localparam int AW = 24;
    localparam int DW = 32;
    localparam int SW = DW / 8;

    typedef struct packed {
        logic          m;
        logic [AW-1:0] addr;
        logic [2:0]    prot;
        logic [DW-1:0] data;
        logic [SW-1:0] strb;
        logic [1:0]    resp;
    } txn_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic [AW-1:0] s_awaddr[2];
    logic [2:0]    s_awprot[2];
    logic          s_awvalid[2];
    logic [DW-1:0] s_wdata[2];
    logic [SW-1:0] s_wstrb[2];
    logic          s_wvalid[2];
    logic          s_bready[2];

    logic       s0_awready, s1_awready, s0_wready, s1_wready, s0_bvalid, s1_bvalid;
    logic [1:0] s0_bresp, s1_bresp;
    wire  [1:0] awr = {s1_awready, s0_awready};
    wire  [1:0] wr  = {s1_wready, s0_wready};
    wire  [1:0] bv  = {s1_bvalid, s0_bvalid};
    wire  [3:0] br  = {s1_bresp, s0_bresp};

    logic [AW-1:0] m_awaddr;
    logic [2:0]    m_awprot;
    logic          m_awvalid, m_awready;
    logic [DW-1:0] m_wdata;
    logic [SW-1:0] m_wstrb;
    logic          m_wvalid, m_wready;
    logic [1:0]    m_bresp;
    logic          m_bvalid, m_bready;

    int checks = 0;
    int errors = 0;
    txn_t exp_q[$];
    txn_t got_q[$];

    // slave model state
    int            aw_delay = 0, w_delay = 0;
    int            aw_cnt, w_cnt;
    logic          aw_got, w_got;
    logic [AW-1:0] cap_addr;
    logic [2:0]    cap_prot;
    logic [DW-1:0] cap_data;
    logic [SW-1:0] cap_strb;
    logic [1:0]    slv_resp = 2'b00;
    int            overlap = 0, early_resp = 0;

    assign m_awready = (aw_cnt >= aw_delay);
    assign m_wready  = (w_cnt >= w_delay);
    assign m_bresp   = slv_resp;

    axil_wr_arbiter_2x1 #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STRB_WIDTH(SW)) dut (
        .clk(clk), .rst(rst),
        .s0_awaddr(s_awaddr[0]), .s0_awprot(s_awprot[0]), .s0_awvalid(s_awvalid[0]), .s0_awready(s0_awready),
        .s0_wdata(s_wdata[0]), .s0_wstrb(s_wstrb[0]), .s0_wvalid(s_wvalid[0]), .s0_wready(s0_wready),
        .s0_bresp(s0_bresp), .s0_bvalid(s0_bvalid), .s0_bready(s_bready[0]),
        .s1_awaddr(s_awaddr[1]), .s1_awprot(s_awprot[1]), .s1_awvalid(s_awvalid[1]), .s1_awready(s1_awready),
        .s1_wdata(s_wdata[1]), .s1_wstrb(s_wstrb[1]), .s1_wvalid(s_wvalid[1]), .s1_wready(s1_wready),
        .s1_bresp(s1_bresp), .s1_bvalid(s1_bvalid), .s1_bready(s_bready[1]),
        .m_awaddr(m_awaddr), .m_awprot(m_awprot), .m_awvalid(m_awvalid), .m_awready(m_awready),
        .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
        .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready)
    );

    always #5 clk = ~clk;

    // Slave: captures AW/W, raises B the cycle after both have arrived.
    always @(posedge clk) begin
        if (rst) begin
            aw_got <= 1'b0; w_got <= 1'b0; m_bvalid <= 1'b0; aw_cnt <= 0; w_cnt <= 0;
        end else begin
            if (m_awvalid && m_awready) begin
                if (aw_got) overlap <= overlap + 1;
                aw_got <= 1'b1; cap_addr <= m_awaddr; cap_prot <= m_awprot; aw_cnt <= 0;
            end else if (m_awvalid) aw_cnt <= aw_cnt + 1;
            if (m_wvalid && m_wready) begin
                if (w_got) overlap <= overlap + 1;
                w_got <= 1'b1; cap_data <= m_wdata; cap_strb <= m_wstrb; w_cnt <= 0;
            end else if (m_wvalid) w_cnt <= w_cnt + 1;
            if (m_bready && !(aw_got && w_got)) early_resp <= early_resp + 1;
            if (m_bvalid && m_bready) begin
                m_bvalid <= 1'b0; aw_got <= 1'b0; w_got <= 1'b0;
            end else if (!m_bvalid && (aw_got || (m_awvalid && m_awready)) &&
                         (w_got || (m_wvalid && m_wready))) begin
                m_bvalid <= 1'b1;
            end
        end
    end

    // Monitor: a completed B on a master port closes one transaction.
    always @(posedge clk) begin
        if (!rst) begin
            if (s0_bvalid && s_bready[0]) got_q.push_back({1'b0, cap_addr, cap_prot, cap_data, cap_strb, s0_bresp});
            if (s1_bvalid && s_bready[1]) got_q.push_back({1'b1, cap_addr, cap_prot, cap_data, cap_strb, s1_bresp});
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors + 1);
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        for (int m = 0; m < 2; m++) begin
            s_awvalid[m] = 1'b0; s_wvalid[m] = 1'b0; s_bready[m] = 1'b0;
        end
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic master_write(input int m, input logic [AW-1:0] addr, input logic [DW-1:0] data,
                                input logic [SW-1:0] strb, input int bhold);
        logic aw_hs, w_hs, b_hs, done;
        int seen;
        done = 1'b0;
        seen = 0;
        s_awaddr[m] = addr;
        s_awprot[m] = (m == 1) ? 3'b001 : 3'b010;
        s_wdata[m] = data;
        s_wstrb[m] = strb;
        s_awvalid[m] = 1'b1;
        s_wvalid[m] = 1'b1;
        s_bready[m] = (bhold == 0);
        for (int cyc = 0; cyc < 300 && !done; cyc++) begin
            @(negedge clk);
            aw_hs = s_awvalid[m] && awr[m];
            w_hs  = s_wvalid[m] && wr[m];
            b_hs  = bv[m] && s_bready[m];
            if (bv[m] && !s_bready[m]) seen++;
            tick();
            if (aw_hs) s_awvalid[m] = 1'b0;
            if (w_hs) s_wvalid[m] = 1'b0;
            if (b_hs) begin
                s_bready[m] = 1'b0;
                done = 1'b1;
            end else if (seen >= bhold) begin
                s_bready[m] = 1'b1;
            end
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL write_timeout master=%0d addr=%h: completed=0 required=1", m, addr);
            s_awvalid[m] = 1'b0; s_wvalid[m] = 1'b0; s_bready[m] = 1'b0;
        end
    endtask

    task automatic test_reset();
        pulse_reset();
        @(negedge clk);
        checks++;
        if ({m_awvalid, m_wvalid, m_bready, awr, wr, bv, br} !== 13'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %b required 0", {m_awvalid, m_wvalid, m_bready, awr, wr, bv, br});
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            @(negedge clk);
            checks++;
            if ({m_awvalid, awr, wr, bv} !== 7'd0) begin
                errors++;
                $display("FAIL idle_quiet cycle %0d: got %b required 0", i, {m_awvalid, awr, wr, bv});
            end
        end
        tick();
    endtask

    task automatic test_single_master();
        txn_t e, g;
        aw_delay = 0; w_delay = 0; slv_resp = 2'b00;
        exp_q.push_back({1'b1, 24'h000100, 3'b001, 32'hDEADBEEF, 4'hF, 2'b00});
        s_awaddr[1] = 24'h000100; s_awprot[1] = 3'b001; s_wdata[1] = 32'hDEADBEEF; s_wstrb[1] = 4'hF;
        s_awvalid[1] = 1'b1; s_wvalid[1] = 1'b1; s_bready[1] = 1'b1;
        @(negedge clk);
        checks++;
        if ({m_awvalid, m_wvalid, awr, wr} !== 6'd0) begin
            errors++;
            $display("FAIL single_cycle0_bubble: got %b required 0", {m_awvalid, m_wvalid, awr, wr});
        end
        tick();
        @(negedge clk);
        checks++;
        if ({m_awvalid, m_wvalid, m_awaddr, m_wdata, m_wstrb, awr, wr, m_bready} !==
            {1'b1, 1'b1, 24'h000100, 32'hDEADBEEF, 4'hF, 2'b10, 2'b10, 1'b0}) begin
            errors++;
            $display("FAIL single_cycle1_fwd: got v=%b%b addr=%h data=%h strb=%h awr=%b wr=%b bready=%b",
                     m_awvalid, m_wvalid, m_awaddr, m_wdata, m_wstrb, awr, wr, m_bready);
        end
        tick();
        s_awvalid[1] = 1'b0; s_wvalid[1] = 1'b0;
        @(negedge clk);
        checks++;
        if ({bv, br, m_bready, m_awvalid} !== {2'b10, 4'b0000, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL single_cycle2_resp: got bv=%b br=%b bready=%b required bv=10 br=0000 bready=1",
                     bv, br, m_bready);
        end
        tick();
        s_bready[1] = 1'b0;
        @(negedge clk);
        checks++;
        if (bv !== 2'b00) begin
            errors++;
            $display("FAIL single_cycle3_idle: got bv=%b required 00", bv);
        end
        checks++;
        if (got_q.size() == 0) begin
            errors++;
            $display("FAIL single_scoreboard: got no transaction required 1");
        end else begin
            g = got_q.pop_front(); e = exp_q.pop_front();
            if (g !== e) begin
                errors++;
                $display("FAIL single_scoreboard: got %h required %h", g, e);
            end
        end
        tick();
    endtask

    task automatic test_tie_round_robin();
        txn_t e, g;
        pulse_reset();
        for (int k = 0; k < 4; k++) begin
            exp_q.push_back({1'b0, 24'h001000 + 24'(k), 3'b010, 32'hA0000000 + 32'(k), 4'hF, 2'b00});
            exp_q.push_back({1'b1, 24'h002000 + 24'(k), 3'b001, 32'hB0000000 + 32'(k), 4'h3, 2'b00});
        end
        fork
            for (int k = 0; k < 4; k++) master_write(0, 24'h001000 + 24'(k), 32'hA0000000 + 32'(k), 4'hF, 0);
            for (int j = 0; j < 4; j++) master_write(1, 24'h002000 + 24'(j), 32'hB0000000 + 32'(j), 4'h3, 0);
        join
        for (int k = 0; k < 8; k++) begin
            checks++;
            if (got_q.size() == 0 || exp_q.size() == 0) begin
                errors++;
                $display("FAIL tie_scoreboard %0d: got %0d entries required 1", k, got_q.size());
            end else begin
                g = got_q.pop_front(); e = exp_q.pop_front();
                if (g !== e) begin
                    errors++;
                    $display("FAIL tie_scoreboard %0d: got %h required %h", k, g, e);
                end
            end
        end
        checks++;
        if (overlap !== 0) begin
            errors++;
            $display("FAIL tie_overlap: got %0d overlapping handshakes required 0", overlap);
        end
        tick();
    endtask

    task automatic test_w_before_aw();
        txn_t e, g;
        aw_delay = 2;
        exp_q.push_back({1'b0, 24'h00ABCD, 3'b010, 32'h12345678, 4'b0101, 2'b00});
        s_wdata[0] = 32'h12345678; s_wstrb[0] = 4'b0101; s_wvalid[0] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if ({m_wvalid, m_awvalid, wr} !== 4'b0000) begin
                errors++;
                $display("FAIL w_early_cycle%0d: got wvalid=%b awvalid=%b wr=%b required 0", i, m_wvalid, m_awvalid, wr);
            end
            tick();
        end
        master_write(0, 24'h00ABCD, 32'h12345678, 4'b0101, 0);
        checks++;
        if (got_q.size() == 0) begin
            errors++;
            $display("FAIL w_first_scoreboard: got no transaction required 1");
        end else begin
            g = got_q.pop_front(); e = exp_q.pop_front();
            if (g !== e) begin
                errors++;
                $display("FAIL w_first_scoreboard: got %h required %h", g, e);
            end
        end
        checks++;
        if (early_resp !== 0) begin
            errors++;
            $display("FAIL w_first_early_resp: got %0d early bready cycles required 0", early_resp);
        end
        aw_delay = 0;
        tick();
    endtask

    task automatic test_backpressure();
        txn_t e, g;
        int n;
        slv_resp = 2'b10;
        exp_q.push_back({1'b0, 24'h000440, 3'b010, 32'hCAFEF00D, 4'hC, 2'b10});
        fork
            master_write(0, 24'h000440, 32'hCAFEF00D, 4'hC, 5);
            begin
                n = 0;
                do begin
                    @(negedge clk);
                    n++;
                end while (!bv[0] && n < 50);
                for (int i = 0; i < 5; i++) begin
                    if (i > 0) @(negedge clk);
                    checks++;
                    if ({m_bready, m_bvalid, bv, br} !== {1'b0, 1'b1, 2'b01, 4'b0010}) begin
                        errors++;
                        $display("FAIL bp_hold cycle%0d: got bready=%b mbvalid=%b bv=%b br=%b required 0 1 01 0010",
                                 i, m_bready, m_bvalid, bv, br);
                    end
                end
            end
        join
        checks++;
        if (got_q.size() == 0) begin
            errors++;
            $display("FAIL bp_scoreboard: got no transaction required 1");
        end else begin
            g = got_q.pop_front(); e = exp_q.pop_front();
            if (g !== e) begin
                errors++;
                $display("FAIL bp_scoreboard: got %h required %h", g, e);
            end
        end
        slv_resp = 2'b00;
        tick();
    endtask

    task automatic test_reset_mid_xfer();
        txn_t e, g;
        int n;
        w_delay = 1000;
        s_awaddr[0] = 24'h000880; s_awprot[0] = 3'b010; s_wdata[0] = 32'h55AA55AA; s_wstrb[0] = 4'hF;
        s_awvalid[0] = 1'b1; s_wvalid[0] = 1'b1; s_bready[0] = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(m_awvalid && m_awready) && n < 20);
        tick();
        s_awvalid[0] = 1'b0;
        @(negedge clk);
        checks++;
        if ({m_awvalid, m_wvalid} !== 2'b01) begin
            errors++;
            $display("FAIL mid_aw_done: got awvalid=%b wvalid=%b required 0 1", m_awvalid, m_wvalid);
        end
        tick();
        rst = 1'b1;
        s_wvalid[0] = 1'b0; s_bready[0] = 1'b0;
        tick();
        rst = 1'b0;
        w_delay = 0;
        @(negedge clk);
        checks++;
        if ({m_awvalid, m_wvalid, m_bready, awr, wr, bv, br} !== 13'd0) begin
            errors++;
            $display("FAIL mid_reset_outputs: got %b required 0", {m_awvalid, m_wvalid, m_bready, awr, wr, bv, br});
        end
        checks++;
        if (got_q.size() != 0) begin
            errors++;
            $display("FAIL mid_reset_no_b: got %0d responses required 0", got_q.size());
            got_q.delete();
        end
        tick();
        exp_q.push_back({1'b0, 24'h000900, 3'b010, 32'h0000_0001, 4'h1, 2'b00});
        exp_q.push_back({1'b1, 24'h000A00, 3'b001, 32'h0000_0002, 4'h2, 2'b00});
        fork
            master_write(0, 24'h000900, 32'h0000_0001, 4'h1, 0);
            master_write(1, 24'h000A00, 32'h0000_0002, 4'h2, 0);
        join
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (got_q.size() == 0 || exp_q.size() == 0) begin
                errors++;
                $display("FAIL mid_tie_scoreboard %0d: got %0d entries required 1", k, got_q.size());
            end else begin
                g = got_q.pop_front(); e = exp_q.pop_front();
                if (g !== e) begin
                    errors++;
                    $display("FAIL mid_tie_scoreboard %0d: got %h required %h", k, g, e);
                end
            end
        end
        tick();
    endtask

    initial begin
        for (int m = 0; m < 2; m++) begin
            s_awaddr[m] = '0; s_awprot[m] = '0; s_awvalid[m] = 1'b0;
            s_wdata[m] = '0; s_wstrb[m] = '0; s_wvalid[m] = 1'b0; s_bready[m] = 1'b0;
        end
        #1;
        test_reset();
        test_single_master();
        test_tie_round_robin();
        test_w_before_aw();
        test_backpressure();
        test_reset_mid_xfer();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
